// File: rtl/l2_line_responder_pkg.sv
// Shared definitions for the L2 line responder: address width, request kinds and FSM states.
package l2_line_responder_pkg;

  localparam int unsigned LINE_ADDR_W = 26;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVICE = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/l2_line_responder_fifo.sv
// Request FIFO holding {kind, line address} entries in arrival order.
// Full and empty come from the entry count, so pointers may wrap freely.
module line_req_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_push;
  logic             do_pop;

  assign full_o      = (occ_q == OCC_W'(DEPTH));
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign head_o      = mem_q[rd_ptr_q];
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;

  // Storage carries no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (do_pop && !do_push) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end
  end

endmodule

// File: rtl/l2_line_responder.sv
// Services L1 line requests after a fixed latency and returns completions in order,
// while counting accepted reads and writes.
module l2_line_responder
  import l2_line_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = LINE_ADDR_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ADDR_W-1:0]      resp_addr,
  output logic                   resp_write,
  output logic [CNT_W-1:0]       l2_reads,
  output logic [CNT_W-1:0]       l2_writes,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   busy
);

  localparam int unsigned ENTRY_W = ADDR_W + 1;
  localparam int unsigned LAT_W   = $clog2(LATENCY + 1);

  state_e             state_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic               resp_valid_q;
  logic [ADDR_W-1:0]  resp_addr_q;
  logic               resp_write_q;
  logic [CNT_W-1:0]   reads_q;
  logic [CNT_W-1:0]   writes_q;

  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;

  line_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({req_write, req_addr}),
    .pop_i       (pop),
    .head_o      (head),
    .occupancy_o (occupancy),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Service sequencer: pop into the holding registers, wait out the latency, then present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_write_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            resp_addr_q  <= head[ADDR_W-1:0];
            resp_write_q <= head[ADDR_W];
            lat_cnt_q    <= LAT_W'(LATENCY - 1);
            state_q      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (lat_cnt_q == '0) begin
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESPOND;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        ST_RESPOND: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics count accepted requests only; they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else if (push) begin
      if (req_kind_e'(req_write) == REQ_WRITE) begin
        writes_q <= writes_q + CNT_W'(1);
      end else begin
        reads_q <= reads_q + CNT_W'(1);
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_addr  = resp_addr_q;
  assign resp_write = resp_write_q;
  assign l2_reads   = reads_q;
  assign l2_writes  = writes_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_l2_line_responder.sv
// Randomised bench for l2_line_responder against a transaction-level queue model.
module tb_l2_line_responder;

  localparam int ADDR_W  = 26;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;
  localparam int CNT_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_write;
  logic [CNT_W-1:0]  l2_reads;
  logic [CNT_W-1:0]  l2_writes;
  logic [2:0]        occupancy;
  logic              busy;

  always #5 clk = ~clk;

  l2_line_responder #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_addr  (resp_addr),
    .resp_write (resp_write),
    .l2_reads   (l2_reads),
    .l2_writes  (l2_writes),
    .occupancy  (occupancy),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Model: queued requests, the request in service, and cycles left before it is presented.
  logic [ADDR_W:0] m_q[$];
  logic [ADDR_W:0] m_cur;
  bit              m_inflight;
  bit              m_resp;
  int              m_wait;
  int              m_reads;
  int              m_writes;
  int              m_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur      = '0;
    m_inflight = 1'b0;
    m_resp     = 1'b0;
    m_wait     = 0;
    m_reads    = 0;
    m_writes   = 0;
  endtask

  task automatic model_step(input bit v, input bit w, input logic [ADDR_W-1:0] a, input bit rr);
    bit acc;
    acc = v && (m_q.size() != DEPTH);
    if (m_resp && rr) begin
      m_resp     = 1'b0;
      m_inflight = 1'b0;
      m_done++;
    end else if (m_inflight && !m_resp) begin
      m_wait--;
      if (m_wait == 0) m_resp = 1'b1;
    end else if (!m_inflight && m_q.size() > 0) begin
      m_cur      = m_q.pop_front();
      m_inflight = 1'b1;
      m_wait     = LATENCY;
    end
    if (acc) begin
      m_q.push_back({w, a});
      if (w) m_writes++;
      else   m_reads++;
    end
  endtask

  task automatic check_all();
    chk("req_ready",  64'(req_ready),  64'(m_q.size() != DEPTH));
    chk("occupancy",  64'(occupancy),  64'(m_q.size()));
    chk("resp_valid", 64'(resp_valid), 64'(m_resp));
    chk("resp_addr",  64'(resp_addr),  64'(m_cur[ADDR_W-1:0]));
    chk("resp_write", 64'(resp_write), 64'(m_cur[ADDR_W]));
    chk("l2_reads",   64'(l2_reads),   64'(m_reads));
    chk("l2_writes",  64'(l2_writes),  64'(m_writes));
    chk("busy",       64'(busy),       64'(m_inflight || m_q.size() > 0));
  endtask

  task automatic cycle(input bit v, input bit w, input logic [ADDR_W-1:0] a, input bit rr);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    resp_ready = rr;
    @(posedge clk);
    model_step(v, w, a, rr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    int done_before;
    int rr_pct;
    m_done = 0;
    model_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    #12;
    check_all();
    rst_n = 1'b1;

    // Single read: response must appear after the fourth edge and last one cycle.
    done_before = m_done;
    cycle(1'b1, 1'b0, 26'h0ABCDEF, 1'b1);
    idle(8);
    chk("single_done", 64'(m_done - done_before), 64'd1);

    // Fill to full under back-pressure, then drain while still offering requests.
    for (int i = 0; i < 8; i++) begin
      ra = ADDR_W'($urandom);
      cycle(1'b1, i[0], ra, 1'b0);
    end
    chk("full_reads_writes", 64'(l2_reads + l2_writes), 64'd6);
    for (int i = 0; i < 10; i++) begin
      ra = ADDR_W'($urandom);
      cycle(1'b1, 1'b1, ra, 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      ra = ADDR_W'($urandom);
      cycle(i < 6, 1'b0, ra, 1'b1);
    end
    idle(20);

    // Mixed traffic R W R W R.
    for (int i = 0; i < 5; i++) begin
      ra = ADDR_W'($urandom);
      cycle(1'b1, (i % 2) == 1, ra, 1'b1);
    end
    idle(30);

    // Random traffic with varying back-pressure.
    for (int blk = 0; blk < 30; blk++) begin
      rr_pct = $urandom_range(10, 100);
      for (int i = 0; i < 50; i++) begin
        ra = ADDR_W'($urandom);
        cycle($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1, ra,
              $urandom_range(1, 100) <= rr_pct);
      end
    end
    idle(30);

    // Reset while in service with two entries still queued.
    for (int i = 0; i < 3; i++) begin
      ra = ADDR_W'($urandom);
      cycle(1'b1, 1'b0, ra, 1'b0);
    end
    chk("pre_reset_occ", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #3;
    rst_n = 1'b1;
    done_before = m_done;
    idle(15);
    chk("post_reset_no_resp", 64'(m_done - done_before), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
